// File: rtl/audio_dac_serializer.sv
// ---------------------------------------------------------------------------
// audio_dac_serializer
//
// Purpose:
//   Sink end of the 32-bit sample path. Once per audio frame it latches the
//   offset-binary sample bus (0x80000000 = silence) and converts it to two's
//   complement by inverting the MSB. It then serializes the word MSB-first to
//   the board audio codec. The input is mono, so the same word is sent on both
//   the left and the right channel.
//
// Configuration:
//   AUDIO_DAC_I2S_MODE_EN  undefined -> left-justified format (LRCK high = left)
//                          defined   -> Philips I2S format (LRCK low = left,
//                                       data delayed one BCLK, CH_BITS >= 33)
//
// Parameters:
//   BCLK_HALF  system clocks per BCLK half-period (>= 2)
//   CH_BITS    BCLK slots per channel (>= 32); a frame is 2*CH_BITS slots
//
// Ports:
//   clock         in   system clock
//   reset         in   synchronous, active-high reset
//   iSound[31:0]  in   offset-binary sample, held stable by the source
//   iMute         in   1 = transmit silence (all-zero two's complement)
//   oSampleTaken  out  one-clock pulse when iSound is latched (frame start)
//   oBclk         out  codec bit clock
//   oLrck         out  codec DAC left/right clock
//   oDacdat       out  codec serial data
// ---------------------------------------------------------------------------
module audio_dac_serializer #(
  parameter int BCLK_HALF = 4,
  parameter int CH_BITS   = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iSound,
  input  logic        iMute,
  output logic        oSampleTaken,
  output logic        oBclk,
  output logic        oLrck,
  output logic        oDacdat
);

  localparam int SLOTS = 2 * CH_BITS;
  localparam int SW    = $clog2(SLOTS);
  localparam int HW    = $clog2(BCLK_HALF);

  // Elaboration-time parameter checks.
  if (BCLK_HALF < 2) begin : g_bad_bclk_half
    $error("audio_dac_serializer: BCLK_HALF must be >= 2");
  end
  if (CH_BITS < 32) begin : g_bad_ch_bits
    $error("audio_dac_serializer: CH_BITS must be >= 32");
  end
`ifdef AUDIO_DAC_I2S_MODE_EN
  if (CH_BITS < 33) begin : g_bad_i2s_ch_bits
    $error("audio_dac_serializer: I2S mode needs CH_BITS >= 33");
  end
`endif

  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic          bclk_q, bclk_d;
  logic [SW-1:0] bit_cnt_q, bit_cnt_d;
  logic          lrck_q, lrck_d;
  logic          dac_q, dac_d;
  logic          taken_q, taken_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   held_q, held_d;

  logic          half_term;
  logic          fall_ev;
  logic [SW-1:0] slot_next;
  logic          is_right;
  logic [SW-1:0] ch_idx;
  logic [31:0]   sample_word;

  assign half_term = (half_cnt_q == HW'(BCLK_HALF - 1));
  // A terminal count while BCLK is high is the 1->0 toggle.
  assign fall_ev   = half_term && bclk_q;

  // Slot that becomes current at the next fall event.
  assign slot_next = (bit_cnt_q == SW'(SLOTS - 1)) ? '0 : bit_cnt_q + SW'(1);
  assign is_right  = (slot_next >= SW'(CH_BITS));
  assign ch_idx    = is_right ? (slot_next - SW'(CH_BITS)) : slot_next;

  // Offset binary -> two's complement is a flip of the MSB.
  assign sample_word = iMute ? 32'h0 : {~iSound[31], iSound[30:0]};

  always_comb begin
    half_cnt_d = half_term ? '0 : half_cnt_q + HW'(1);
    bclk_d     = half_term ? ~bclk_q : bclk_q;
    bit_cnt_d  = bit_cnt_q;
    lrck_d     = lrck_q;
    dac_d      = dac_q;
    taken_d    = 1'b0;
    shift_d    = shift_q;
    held_d     = held_q;

    if (fall_ev) begin
      bit_cnt_d = slot_next;
`ifdef AUDIO_DAC_I2S_MODE_EN
      // I2S: slot 0 of each channel still carries the LSB of the word sent
      // before it, and the new word's MSB follows one BCLK later. held_q is
      // both the previous right word and the current left word, so its LSB
      // is the right bit for both channel-start slots.
      lrck_d = is_right;
      if (slot_next == '0) begin
        held_d  = sample_word;
        shift_d = sample_word;
        dac_d   = held_q[0];
        taken_d = 1'b1;
      end else if (slot_next == SW'(CH_BITS)) begin
        shift_d = held_q;
        dac_d   = held_q[0];
      end else if (ch_idx <= SW'(32)) begin
        dac_d   = shift_q[31];
        shift_d = shift_q << 1;
      end else begin
        dac_d   = 1'b0;
      end
`else
      // Left-justified: the MSB goes out in the channel's first slot. The
      // shifter is loaded pre-shifted because that MSB is driven straight
      // from the loaded word on the same edge.
      lrck_d = ~is_right;
      if (slot_next == '0) begin
        held_d  = sample_word;
        shift_d = sample_word << 1;
        dac_d   = sample_word[31];
        taken_d = 1'b1;
      end else if (slot_next == SW'(CH_BITS)) begin
        shift_d = held_q << 1;
        dac_d   = held_q[31];
      end else if (ch_idx < SW'(32)) begin
        dac_d   = shift_q[31];
        shift_d = shift_q << 1;
      end else begin
        dac_d   = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      half_cnt_q <= '0;
      bclk_q     <= 1'b0;
      // Parked on the last slot so that the first fall event is a frame start.
      bit_cnt_q  <= SW'(SLOTS - 1);
      lrck_q     <= 1'b0;
      dac_q      <= 1'b0;
      taken_q    <= 1'b0;
      shift_q    <= '0;
      held_q     <= '0;
    end else begin
      half_cnt_q <= half_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      dac_q      <= dac_d;
      taken_q    <= taken_d;
      shift_q    <= shift_d;
      held_q     <= held_d;
    end
  end

  assign oSampleTaken = taken_q;
  assign oBclk        = bclk_q;
  assign oLrck        = lrck_q;
  assign oDacdat      = dac_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
`timescale 1ns/1ps
module tb_audio_dac_serializer;

  localparam int H = 4;
`ifdef AUDIO_DAC_I2S_MODE_EN
  localparam int C   = 34;
  localparam bit I2S = 1'b1;
`else
  localparam int C   = 32;
  localparam bit I2S = 1'b0;
`endif
  localparam int FRAME = 2 * C * 2 * H;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [31:0] snd  = 32'h8000_0000;
  logic        mute = 1'b0;
  logic        taken, bclk, lrck, dac;

  audio_dac_serializer #(.BCLK_HALF(H), .CH_BITS(C)) dut (
    .clock        (clk),
    .reset        (rst),
    .iSound       (snd),
    .iMute        (mute),
    .oSampleTaken (taken),
    .oBclk        (bclk),
    .oLrck        (lrck),
    .oDacdat      (dac)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // ------------------------------------------------------------------
  // Reference model: expected outputs derived from the number of clocks
  // since reset release. Fall event m happens at clock 2*H*m; it opens
  // slot (m-1) mod 2C of frame (m-1) div 2C.
  // ------------------------------------------------------------------
  bit          model_on = 1'b0;
  int          t        = 0;
  logic [31:0] words[int];
  logic [3:0]  exp_v    = 4'b0;   // {taken, bclk, lrck, dac}

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        model_on = 1'b1;
        t        = 0;
        words.delete();
        exp_v    = 4'b0;
      end else if (model_on) begin
        int m, s, f, idx;
        logic e_tk, e_bclk, e_lrck, e_dac;
        logic [31:0] w, prev;
        t++;
        m      = t / (2 * H);
        e_bclk = ((t / H) % 2) == 1;
        e_tk   = 1'b0;
        e_lrck = 1'b0;
        e_dac  = 1'b0;
        if (m >= 1) begin
          s = (m - 1) % (2 * C);
          f = (m - 1) / (2 * C);
          if ((t % (2 * H)) == 0 && s == 0) begin
            words[f] = mute ? 32'h0 : (snd ^ 32'h8000_0000);
            e_tk     = 1'b1;
          end
          w   = words[f];
          idx = s % C;
          if (!I2S) begin
            e_lrck = (s < C);
            e_dac  = (idx < 32) ? w[31 - idx] : 1'b0;
          end else begin
            e_lrck = (s >= C);
            if (idx == 0) begin
              prev  = (s >= C) ? w : ((f == 0) ? 32'h0 : words[f - 1]);
              e_dac = prev[0];
            end else if (idx <= 32) begin
              e_dac = w[32 - idx];
            end
          end
        end
        exp_v = {e_tk, e_bclk, e_lrck, e_dac};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_on) check("cycle", {60'b0, taken, bclk, lrck, dac}, {60'b0, exp_v});
    end
  end

  // ------------------------------------------------------------------
  // Helpers
  // ------------------------------------------------------------------
  task automatic wait_taken(output int n);
    bit ok;
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < FRAME + 16; i++) begin
      @(negedge clk);
      n++;
      if (taken === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk_cnt++;
      $display("FAIL taken_timeout: no oSampleTaken in %0d clocks, expected one", FRAME + 16);
    end
  endtask

  // Called at the negedge where oSampleTaken is seen. Samples each slot in
  // the middle of its BCLK period and disturbs iSound/iMute mid-frame.
  task automatic capture(input logic [31:0] glitch, output logic [31:0] lw,
                         output logic [31:0] rw, output int lr_left);
    int first;
    first   = I2S ? 1 : 0;
    lw      = 32'h0;
    rw      = 32'h0;
    lr_left = 0;
    repeat (H) @(negedge clk);
    for (int k = 0; k < 2 * C; k++) begin
      if (k == 5) snd = glitch;
      if (k == 7) mute = ~mute;
      if (k >= first && k < first + 32) lw = {lw[30:0], dac};
      if (k >= C + first && k < C + first + 32) rw = {rw[30:0], dac};
      if (k < C && lrck === 1'b1) lr_left++;
      if (k != 2 * C - 1) repeat (2 * H) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] sound;
    logic        mute;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, lr_left;
    logic [31:0] lw, rw;

    vecs[0] = '{32'hC000_0001, 1'b0, 32'h4000_0001};
    vecs[1] = '{32'h0000_0000, 1'b0, 32'h8000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF};
    vecs[4] = '{32'h8000_0000, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFF};
    vecs[6] = '{32'h1234_5678, 1'b0, 32'h9234_5678};

    // Reset for three clocks, then first-sample latency and frame period.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {60'b0, taken, bclk, lrck, dac}, 64'h0);
    rst = 1'b0;
    wait_taken(n);
    check("first_taken_latency", n, 2 * H);
    wait_taken(n);
    check("sample_period", n, FRAME);

    // Table: inputs applied mid-frame take effect at the next frame start;
    // changes inside the captured frame must not disturb it.
    for (int i = 0; i < 7; i++) begin
      snd  = vecs[i].sound;
      mute = vecs[i].mute;
      wait_taken(n);
      capture(~vecs[i].sound, lw, rw, lr_left);
      check("left_word", lw, vecs[i].word);
      check("right_word", rw, vecs[i].word);
      check("lrck_left_slots", lr_left, I2S ? 0 : C);
      $display("vec %0d sound=%08h mute=%0d left=%08h right=%08h", i, vecs[i].sound,
               vecs[i].mute, lw, rw);
    end

    // Reset pulsed in slot 40 while BCLK is high, then clean restart.
    snd  = 32'h1234_5678;
    mute = 1'b0;
    wait_taken(n);
    wait_taken(n);
    repeat (40 * 2 * H + H + 1) @(negedge clk);
    check("bclk_before_reset", bclk, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset", {60'b0, taken, bclk, lrck, dac}, 64'h0);
    rst = 1'b0;
    wait_taken(n);
    check("restart_latency", n, 2 * H);
    capture(32'hDEAD_BEEF, lw, rw, lr_left);
    check("restart_left", lw, 32'h9234_5678);
    check("restart_right", rw, 32'h9234_5678);
    $display("restart left=%08h right=%08h", lw, rw);

    // Random inputs at random times; the cycle model checks every clock.
    snd  = 32'h1234_5678;
    mute = 1'b0;
    for (int i = 0; i < 10; i++) begin
      snd  = $urandom;
      mute = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, FRAME)) @(negedge clk);
      $display("rand %0d sound=%08h mute=%0d", i, snd, mute);
    end
    repeat (FRAME) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
